image_stitch_merge: RTL

IMAGE_STITCH_MERGE -- requirements
Module: image_stitch_merge

---
 rtl/image_stitch_merge_pkg.sv | 34 +++
 rtl/stitch_line_fifo.sv | 71 +++++++
 rtl/image_stitch_merge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/image_stitch_merge_pkg.sv
// Shared definitions for the image stitch merge block.
// Holds the line-assembly FSM state type, the default geometry parameters and
// the clog2-based helpers that size the counters and FIFO pointers.
package image_stitch_merge_pkg;

  // Output line assembly: wait for left, forward left, drain right, blank.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLeft  = 2'd1,
    StRight = 2'd2,
    StGap   = 2'd3
  } stitch_state_e;

  localparam int unsigned DefLeftWidth  = 960;
  localparam int unsigned DefRightWidth = 960;
  localparam int unsigned DefFifoDepth  = 1024;
  localparam int unsigned DefPixelWidth = 8;

  // Bits needed to index n distinct values, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Per-line right push counter must also represent the saturated value RIGHT_WIDTH.
  function automatic int unsigned push_cnt_width(input int unsigned right_width);
    return cnt_width(right_width + 1);
  endfunction

  // FIFO pointer: address bits plus one wrap bit for full/empty disambiguation.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return cnt_width(depth) + 1;
  endfunction

endpackage

// File: rtl/stitch_line_fifo.sv
// Synchronous show-ahead FIFO buffering right-segment pixels of one line.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset (pointers only)
//   flush_i           empties the FIFO; overrides push/pop in the same cycle
//   push_i, wdata_i   write request and data (ignored while full)
//   pop_i             read request (ignored while empty)
//   rdata_o           head entry, valid whenever empty_o is low
//   full_o, empty_o   occupancy flags
module stitch_line_fifo
  import image_stitch_merge_pkg::*;
#(
  parameter int unsigned Depth     = 1024,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW  = ptr_width(Depth);
  localparam int unsigned AddrW = PtrW - 1;

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] mem_q [Depth];
  logic                 do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Show-ahead: head entry is visible without a pop.
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/image_stitch_merge.sv
// Stitches a left and a right camera line into one output line of
// LEFT_WIDTH + RIGHT_WIDTH pixels, left segment first. Left pixels are
// forwarded directly; right pixels are buffered in a line FIFO and drained
// once the left segment is complete. left_in_vsync is the frame reference.
// Ports:
//   clk, rst_n                          pixel clock, asynchronous active-low reset
//   left_in_vsync/href/de/data          left camera stream (frame reference)
//   right_in_href/de/data               right camera stream
//   image_out_vsync/href/de/data        stitched stream (vsync delayed 1 clk)
//   stitch_err                          sticky: left pixel overran a line or FIFO overflowed
// Build option: define STITCH_SEAM_MARK_EN to replace the first right-segment
// output pixel of every line with all-ones. Timing is identical either way.
module image_stitch_merge
  import image_stitch_merge_pkg::*;
#(
  parameter int unsigned LEFT_WIDTH       = DefLeftWidth,
  parameter int unsigned RIGHT_WIDTH      = DefRightWidth,
  parameter int unsigned FIFO_DEPTH       = DefFifoDepth,
  parameter int unsigned PIXEL_DATA_WIDTH = DefPixelWidth
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        left_in_vsync,
  input  logic                        left_in_href,
  input  logic                        left_in_de,
  input  logic [PIXEL_DATA_WIDTH-1:0] left_in_data,
  input  logic                        right_in_href,
  input  logic                        right_in_de,
  input  logic [PIXEL_DATA_WIDTH-1:0] right_in_data,
  output logic                        image_out_vsync,
  output logic                        image_out_href,
  output logic                        image_out_de,
  output logic [PIXEL_DATA_WIDTH-1:0] image_out_data,
  output logic                        stitch_err
);

  localparam int unsigned LeftCntW = cnt_width(LEFT_WIDTH);
  localparam int unsigned PushCntW = push_cnt_width(RIGHT_WIDTH);
  localparam int unsigned PopCntW  = cnt_width(RIGHT_WIDTH);
  localparam int unsigned Pw       = PIXEL_DATA_WIDTH;

  stitch_state_e state_q, state_d;

  logic                vsync_q;
  logic                right_href_q;
  logic [LeftCntW-1:0] left_cnt_q, left_cnt_d;
  logic [PushCntW-1:0] right_cnt_q, right_cnt_d;
  logic [PopCntW-1:0]  pop_cnt_q, pop_cnt_d;
  logic                out_href_q, out_href_d;
  logic                out_de_q, out_de_d;
  logic [Pw-1:0]       out_data_q, out_data_d;
  logic                err_q, err_d;

  logic          valid_l, valid_r, vsync_fall;
  logic          push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic          left_drop, overflow;
  logic [Pw-1:0] fifo_rdata;

  assign valid_l    = left_in_href & left_in_de;
  assign valid_r    = right_in_href & right_in_de;
  assign vsync_fall = vsync_q & ~left_in_vsync;

  // ---------------------------------------------------------------------------
  // Right-side intake: at most RIGHT_WIDTH pushes per right href run.
  // ---------------------------------------------------------------------------
  assign push_req  = valid_r && (right_cnt_q < PushCntW'(RIGHT_WIDTH));
  assign fifo_push = push_req & ~fifo_full & ~vsync_fall;
  assign overflow  = push_req & fifo_full & ~vsync_fall;

  always_comb begin
    right_cnt_d = right_cnt_q;
    if (vsync_fall) begin
      right_cnt_d = '0;
    end else if (right_href_q && !right_in_href) begin
      // End of a right line re-arms the per-line limit.
      right_cnt_d = '0;
    end else if (push_req) begin
      right_cnt_d = right_cnt_q + 1'b1;
    end
  end

  stitch_line_fifo #(
    .Depth     (FIFO_DEPTH),
    .DataWidth (PIXEL_DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (vsync_fall),
    .push_i  (fifo_push),
    .wdata_i (right_in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Line assembly FSM and registered output stage.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    left_cnt_d = left_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    out_href_d = 1'b0;
    out_de_d   = 1'b0;
    out_data_d = out_data_q;
    fifo_pop   = 1'b0;
    left_drop  = 1'b0;

    unique case (state_q)
      StIdle, StLeft: begin
        if (state_q == StLeft) out_href_d = 1'b1;
        // left_cnt_q is zero in StIdle, so the first pixel is pixel 0.
        if (valid_l) begin
          out_href_d = 1'b1;
          out_de_d   = 1'b1;
          out_data_d = left_in_data;
          if (left_cnt_q == LeftCntW'(LEFT_WIDTH - 1)) begin
            state_d    = StRight;
            left_cnt_d = '0;
          end else begin
            state_d    = StLeft;
            left_cnt_d = left_cnt_q + 1'b1;
          end
        end
      end

      StRight: begin
        out_href_d = 1'b1;
        left_drop  = valid_l;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          out_de_d   = 1'b1;
          out_data_d = fifo_rdata;
`ifdef STITCH_SEAM_MARK_EN
          if (pop_cnt_q == '0) out_data_d = '1;
`endif
          if (pop_cnt_q == PopCntW'(RIGHT_WIDTH - 1)) begin
            state_d   = StGap;
            pop_cnt_d = '0;
          end else begin
            pop_cnt_d = pop_cnt_q + 1'b1;
          end
        end
      end

      StGap: begin
        left_drop = valid_l;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Frame end aborts whatever line is in flight.
    if (vsync_fall) begin
      state_d    = StIdle;
      left_cnt_d = '0;
      pop_cnt_d  = '0;
      out_href_d = 1'b0;
      out_de_d   = 1'b0;
      out_data_d = out_data_q;
      fifo_pop   = 1'b0;
      left_drop  = 1'b0;
    end
  end

  assign err_d = err_q | left_drop | overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b0;
      right_href_q <= 1'b0;
      left_cnt_q   <= '0;
      right_cnt_q  <= '0;
      pop_cnt_q    <= '0;
      out_href_q   <= 1'b0;
      out_de_q     <= 1'b0;
      out_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= left_in_vsync;
      right_href_q <= right_in_href;
      left_cnt_q   <= left_cnt_d;
      right_cnt_q  <= right_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      out_href_q   <= out_href_d;
      out_de_q     <= out_de_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
    end
  end

  assign image_out_vsync = vsync_q;
  assign image_out_href  = out_href_q;
  assign image_out_de    = out_de_q;
  assign image_out_data  = out_data_q;
  assign stitch_err      = err_q;

endmodule
